// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample loader.
package fft_pkg;
  localparam int DATA_W      = 16;
  localparam int N           = 8;
  localparam int LOG2N       = 3;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {FILL, WRITE, START, BUSY} ld_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream and FFT-core bus of the loader; slave = loader, master = driver side.
interface fft_sample_loader_if;
  import fft_pkg::*;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     flush;
  logic                     fft_ready;
  logic                     frame_write;
  logic                     frame_start;
  logic [N*DATA_W-1:0]      out_real;
  logic [N*DATA_W-1:0]      out_imag;
  logic [7:0]               frame_count;
  logic                     timeout_err;

  modport slave (
    input  in_valid, in_real, in_imag, flush, fft_ready,
    output in_ready, frame_write, frame_start, out_real, out_imag, frame_count, timeout_err
  );
  modport master (
    output in_valid, in_real, in_imag, flush, fft_ready,
    input  in_ready, frame_write, frame_start, out_real, out_imag, frame_count, timeout_err
  );
endinterface

// File: rtl/fft_prescale.sv
// Per-component input scaling; FFT_LOADER_PRESCALE_EN selects round-and-shift by 1/8,
// otherwise the component passes through unchanged.
module fft_prescale
  import fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_o
);
`ifdef FFT_LOADER_PRESCALE_EN
  // One guard bit keeps x+4 exact; after >>>3 the result always fits DATA_W.
  logic signed [DATA_W:0] sum;
  assign sum = {x_i[DATA_W-1], x_i} + (DATA_W+1)'(4);
  assign y_o = DATA_W'(sum >>> 3);
`else
  assign y_o = x_i;
`endif
endmodule

// File: rtl/fft_sample_loader.sv
// Assembles 8 streamed complex samples into a frame, hands it to the FFT core
// with write/start pulses and waits for ready under a watchdog.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  fft_sample_loader_if.slave  bus
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  ld_state_e                      state_q, state_d;
  logic [LOG2N-1:0]               cnt_q, cnt_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [7:0]                     fcnt_q, fcnt_d;
  logic                           err_q, err_d;
  logic [N-1:0][DATA_W-1:0]       re_q, im_q;
  logic                           in_ready, accept;
  cplx_t                          smp;

  fft_prescale u_pre_re (.x_i(bus.in_real), .y_o(smp.re));
  fft_prescale u_pre_im (.x_i(bus.in_imag), .y_o(smp.im));

  assign in_ready = (state_q == FILL) && !bus.flush && !rst;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    case (state_q)
      FILL: begin
        if (bus.flush) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LOG2N'(N-1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: state_d = START;
      START: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // A core that never answers must not wedge the stream: abort, keep count.
        if (bus.fft_ready) begin
          fcnt_d  = fcnt_q + 8'd1;
          state_d = FILL;
        end else if (wd_q == WD_W'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      wd_q    <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      if (accept) begin
        re_q[cnt_q] <= smp.re;
        im_q[cnt_q] <= smp.im;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.frame_write = (state_q == WRITE);
  assign bus.frame_start = (state_q == START);
  assign bus.out_real    = re_q;
  assign bus.out_imag    = im_q;
  assign bus.frame_count = fcnt_q;
  assign bus.timeout_err = err_q;
endmodule
